trig_pulse_wordgen: RTL and testbench
=====================================

TRIG_PULSE_WORDGEN -- requirements
Module: trig_pulse_wordgen

Interface
- REQ-001 SHALL have parameter DELAY_BITS, default 16: width of the delay and spacing ports.
- REQ-002 SHALL have parameter WIDTH_BITS, default 8: width of the width and count ports.
- REQ-003 SHALL have port clock  input  1  divided (word-rate) clock, the same clock that drives the serializer CLKDIV.
- REQ-004 SHALL have port reset  input  1  reset; asynchronous, active-high.
- REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst.
- REQ-006 SHALL have port delay  input  DELAY_BITS  bit-times from the burst origin to the first rising edge.
- REQ-007 SHALL have port width  input  WIDTH_BITS  high bit-times per pulse.
- REQ-008 SHALL have port count  input  WIDTH_BITS  number of pulses; 0 is treated as 1.
- REQ-009 SHALL have port spacing  input  DELAY_BITS  bit-times from one rising edge to the next.
- REQ-010 SHALL have port word  output  4  parallel word for a 4:1 SDR serializer; word[0] is serialized first (D1).
- REQ-011 SHALL have port busy  output  1  high while a burst is being emitted.
- REQ-012 SHALL have port done  output  1  one-cycle pulse at the end of a burst.

Function
- REQ-013 SHALL number bit-times t from 0, where t=0 is word[0] of the first word after start is accepted; word bit i of the n-th word is t=4n+i.
- REQ-014 SHALL place pulse k (k=0..count-1) high over t in [delay+k*S, delay+k*S+width), where S = max(spacing, width+1, 4).
- REQ-015 SHALL latch delay, width, count and spacing on the clock edge where start is accepted; port changes during a burst SHALL have no effect.
- REQ-016 SHALL implement states IDLE and RUN: IDLE->RUN when start=1 and width!=0; RUN->IDLE on the cycle the word containing the last high bit of pulse count-1 is registered.
- REQ-017 SHALL register word; the first burst word (t=0..3) SHALL appear on the cycle after start is sampled.
- REQ-018 SHALL correctly form any word that contains the tail of one pulse and the head of the next.
- REQ-019 SHALL assert busy on the cycle word first carries burst data and hold it through the final burst word; done SHALL be high together with that final word.
- REQ-020 SHALL ignore start while in RUN (no restart, no queuing).
- REQ-021 SHALL, when start=1 with width=0, stay in IDLE, emit no high bits and pulse done on the next cycle.
- REQ-022 SHALL hold word=4'b0000 in IDLE (except as given in REQ-026).
- REQ-023 SHALL use internal bit-position arithmetic at least DELAY_BITS+WIDTH_BITS+2 bits wide, so that positions never wrap within a burst.

Reset
- REQ-024 SHALL, while reset is high, force state=IDLE, word=0, busy=0, done=0 and clear all latched settings and position counters, independent of clock.
- REQ-025 SHALL, on reset asserted mid-burst, abandon the burst with no done pulse; the first start after reset is released SHALL begin a fresh burst.

Configuration
- REQ-026 SHALL, with macro TRIG_PULSE_WORDGEN_PRBS_EN defined, add input train (1 bit); when in IDLE with train=1, word carries PRBS-7 (x^7+x^6+1, seed 7'h7F, reset to seed, 4 bits per cycle, word[0] first); RUN overrides PRBS output; the LFSR holds while in RUN.
- REQ-027 SHALL, with TRIG_PULSE_WORDGEN_PRBS_EN undefined, have no train port and no LFSR; IDLE word is always 0.

Verification
- REQ-028 SHALL cover: delay=0, width=4, count=1, start -> cycle+1 word=4'b1111, busy=1, done=1; cycle+2 word=0, busy=0.
- REQ-029 SHALL cover: delay=2, width=3, count=1 -> words 4'b1100 then 4'b0001 (done here), then 0.
- REQ-030 SHALL cover: delay=0, width=2, count=3, spacing=8 -> words 0011,0000,0011,0000,0011 (done on the fifth word).
- REQ-031 SHALL cover: delay=0, width=2, count=2, spacing=2 (clamped to 4) -> words 0011,0011; start re-pulsed on the second cycle is ignored.
- REQ-032 SHALL cover: reset asserted mid-burst in the spacing=8 case -> word=0 and busy=0 without a clock edge, no done; a later start replays the full burst.
- REQ-033 SHALL cover (PRBS_EN build): train=1 in IDLE -> word stream matches a bit-serial PRBS-7 model, repeats with a period of 127 cycles, and the LFSR never reaches all-zero.

Source files
------------

// File: rtl/trig_pulse_wordgen.sv
// Trigger pulse-train generator producing 4-bit words for a 4:1 SDR serializer.
// Optional PRBS-7 training pattern in IDLE when TRIG_PULSE_WORDGEN_PRBS_EN is defined.
module trig_pulse_wordgen #(
  parameter int DELAY_BITS = 16,
  parameter int WIDTH_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DELAY_BITS-1:0] delay,
  input  logic [WIDTH_BITS-1:0] width,
  input  logic [WIDTH_BITS-1:0] count,
  input  logic [DELAY_BITS-1:0] spacing,
`ifdef TRIG_PULSE_WORDGEN_PRBS_EN
  input  logic                  train,
`endif
  output logic [3:0]            word,
  output logic                  busy,
  output logic                  done
);

  // Bit positions are wide enough that delay + (count-1)*step + width + 4 never wraps.
  localparam int POS_W = DELAY_BITS + WIDTH_BITS + 2;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  // Settings latched when start is accepted.
  logic [WIDTH_BITS-1:0] width_q;
  logic [WIDTH_BITS-1:0] last_q;
  logic [POS_W-1:0]      step_q;

  // Position of the word being formed and the first pulse not yet finished.
  logic [POS_W-1:0]      base_q;
  logic [POS_W-1:0]      edge_q;
  logic [WIDTH_BITS-1:0] k_q;

  logic                  run;
  logic [WIDTH_BITS-1:0] eff_width;
  logic [WIDTH_BITS-1:0] eff_last;
  logic [POS_W-1:0]      new_step;
  logic [POS_W-1:0]      eff_step;
  logic [POS_W-1:0]      cur_base;
  logic [POS_W-1:0]      cur_edge;
  logic [WIDTH_BITS-1:0] cur_k;
  logic [POS_W-1:0]      cur_end;
  logic [POS_W-1:0]      nxt_edge;
  logic [POS_W-1:0]      nxt_end;
  logic [POS_W-1:0]      t;
  logic                  has_next;
  logic                  pulse_ends;
  logic                  last_word;
  logic [3:0]            next_word;

  // In IDLE the first word is formed straight from the ports so it can be
  // registered on the same edge that accepts start.
  always_comb begin
    run       = (state == RUN);
    new_step  = POS_W'(spacing);
    if (POS_W'(width) + POS_W'(1) > new_step) new_step = POS_W'(width) + POS_W'(1);
    if (new_step < POS_W'(4)) new_step = POS_W'(4);
    eff_width = run ? width_q : width;
    eff_last  = run ? last_q : ((count == '0) ? '0 : count - WIDTH_BITS'(1));
    eff_step  = run ? step_q : new_step;
    cur_base  = run ? base_q : '0;
    cur_edge  = run ? edge_q : POS_W'(delay);
    cur_k     = run ? k_q : '0;
    cur_end   = cur_edge + POS_W'(eff_width);
    nxt_edge  = cur_edge + eff_step;
    nxt_end   = nxt_edge + POS_W'(eff_width);
    has_next  = (cur_k != eff_last);
    // Step >= width+1 and >= 4, so one word touches at most the current and next pulse.
    t         = '0;
    next_word = '0;
    for (int i = 0; i < 4; i++) begin
      t = cur_base + POS_W'(i);
      next_word[i] = ((t >= cur_edge) && (t < cur_end)) ||
                     (has_next && (t >= nxt_edge) && (t < nxt_end));
    end
    pulse_ends = (cur_end <= cur_base + POS_W'(4));
    last_word  = pulse_ends && !has_next;
  end

`ifdef TRIG_PULSE_WORDGEN_PRBS_EN
  logic [6:0] lfsr;
  logic [6:0] lfsr_next;
  logic [3:0] prbs_bits;
  logic       fb;

  // x^7 + x^6 + 1, four serial steps per word; word[0] carries the first bit.
  always_comb begin
    lfsr_next = lfsr;
    prbs_bits = '0;
    fb        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fb           = lfsr_next[6] ^ lfsr_next[5];
      prbs_bits[i] = fb;
      lfsr_next    = {lfsr_next[5:0], fb};
    end
  end
`endif

  // start is a single-cycle request sampled only in IDLE; it has no ready
  // handshake, so a start seen during RUN is simply dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      word    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      width_q <= '0;
      last_q  <= '0;
      step_q  <= '0;
      base_q  <= '0;
      edge_q  <= '0;
      k_q     <= '0;
`ifdef TRIG_PULSE_WORDGEN_PRBS_EN
      lfsr    <= 7'h7F;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (width != '0)) begin
            width_q <= width;
            last_q  <= eff_last;
            step_q  <= new_step;
            word    <= next_word;
            busy    <= 1'b1;
            base_q  <= cur_base + POS_W'(4);
            if (pulse_ends) begin
              k_q    <= cur_k + WIDTH_BITS'(1);
              edge_q <= nxt_edge;
            end else begin
              k_q    <= cur_k;
              edge_q <= cur_edge;
            end
            // A burst that fits in one word finishes on the accepting edge.
            if (last_word) done <= 1'b1;
            else           state <= RUN;
          end else begin
            busy <= 1'b0;
            word <= '0;
            if (start) done <= 1'b1;
`ifdef TRIG_PULSE_WORDGEN_PRBS_EN
            else if (train) begin
              word <= prbs_bits;
              lfsr <= lfsr_next;
            end
`endif
          end
        end
        RUN: begin
          word   <= next_word;
          busy   <= 1'b1;
          base_q <= cur_base + POS_W'(4);
          if (pulse_ends) begin
            k_q    <= cur_k + WIDTH_BITS'(1);
            edge_q <= nxt_edge;
          end
          if (last_word) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_pulse_wordgen.sv
// Randomized scoreboard bench for trig_pulse_wordgen; expected words come from
// a bit-time model of the pulse train, checked by an independent monitor.
module tb_trig_pulse_wordgen;
  localparam int DB = 16;
  localparam int WB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [DB-1:0] delay;
  logic [DB-1:0] spacing;
  logic [WB-1:0] width;
  logic [WB-1:0] count;
  logic [3:0]    word;
  logic          busy;
  logic          done;
`ifdef TRIG_PULSE_WORDGEN_PRBS_EN
  logic          train;
`endif

  trig_pulse_wordgen #(.DELAY_BITS(DB), .WIDTH_BITS(WB)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .delay   (delay),
    .width   (width),
    .count   (count),
    .spacing (spacing),
`ifdef TRIG_PULSE_WORDGEN_PRBS_EN
    .train   (train),
`endif
    .word    (word),
    .busy    (busy),
    .done    (done)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  logic [4:0] exp_q[$];   // {done, word}
  int idle_done_due = 0;
  bit idle_chk_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a bit-time t is high when it lies inside any pulse window.
  function automatic int step_of(input int s, input int w);
    int r;
    r = s;
    if (w + 1 > r) r = w + 1;
    if (r < 4) r = 4;
    return r;
  endfunction

  function automatic bit pulse_high(input int t, input int d, input int w, input int c, input int s);
    for (int k = 0; k < c; k++) begin
      if (t >= d + k * s && t < d + k * s + w) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int push_model(input int d, input int w, input int c, input int s);
    int cc, st, last_t, nw;
    logic [3:0] wd;
    if (w == 0) begin
      idle_done_due = 1;
      return 0;
    end
    cc = (c == 0) ? 1 : c;
    st = step_of(s, w);
    last_t = d + (cc - 1) * st + w - 1;
    nw = last_t / 4 + 1;
    for (int n = 0; n < nw; n++) begin
      for (int i = 0; i < 4; i++) wd[i] = pulse_high(4 * n + i, d, w, cc, st);
      exp_q.push_back({(n == nw - 1), wd});
    end
    return nw;
  endfunction

  // Monitor: pops one expected word per busy cycle, checks quiet outputs otherwise.
  always @(negedge clock) begin
    logic [4:0] e;
    if (!reset) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got word %0h done %0b, expected no burst", word, done);
        end else begin
          e = exp_q.pop_front();
          check("burst_word", word, e[3:0]);
          check("burst_done", done, e[4]);
        end
      end else if (idle_chk_en) begin
        check("idle_word", word, 0);
        check("idle_done", done, (idle_done_due != 0));
        idle_done_due = 0;
      end
    end
  end

  // Driver tasks
  task automatic scramble_ports();
    delay   = DB'($urandom);
    width   = WB'($urandom);
    count   = WB'($urandom);
    spacing = DB'($urandom);
  endtask

  task automatic issue_burst(input int d, input int w, input int c, input int s, input bit repulse);
    int nw;
    @(negedge clock);
    delay = DB'(d); width = WB'(w); count = WB'(c); spacing = DB'(s); start = 1'b1;
    @(posedge clock);
    nw = push_model(d, w, c, s);
    @(negedge clock);
    start = 1'b0;
    scramble_ports();
    if (repulse && nw >= 2) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clock);
      #2;
      if (!busy && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL burst_timeout: busy %0b, %0d words outstanding, expected idle", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

`ifdef TRIG_PULSE_WORDGEN_PRBS_EN
  task automatic prbs_test();
    logic [6:0] m;
    logic [3:0] exp_w, prev;
    logic [3:0] hist[0:126];
    bit b;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    idle_chk_en = 1'b0;
    train = 1'b1;
    m = 7'h7F;
    prev = 4'hF;
    for (int n = 0; n < 254; n++) begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        b = m[6] ^ m[5];
        exp_w[i] = b;
        m = {m[5:0], b};
      end
      check("prbs_word", word, exp_w);
      if (n < 127) hist[n] = word;
      else check("prbs_period", word, hist[n - 127]);
      check("prbs_nonzero", ({prev, word} != 8'h00), 1);
      prev = word;
    end
    train = 1'b0;
    @(negedge clock);
    #1;
    idle_chk_en = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0;
    delay = '0; width = '0; count = '0; spacing = '0;
`ifdef TRIG_PULSE_WORDGEN_PRBS_EN
    train = 1'b0;
`endif
    #1;
    check("reset_word", word, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Directed cases
    issue_burst(0, 4, 1, 0, 0);  wait_idle();   // single full word
    issue_burst(2, 3, 1, 0, 0);  wait_idle();   // straddles two words
    issue_burst(0, 2, 3, 8, 0);  wait_idle();   // gap words between pulses
    issue_burst(0, 2, 2, 2, 1);  wait_idle();   // spacing clamped, start re-pulsed
    issue_burst(2, 3, 2, 0, 0);  wait_idle();   // tail and head in one word
    issue_burst(5, 0, 3, 4, 0);  wait_idle();   // zero width
    issue_burst(1, 1, 0, 0, 0);  wait_idle();   // count 0 behaves as 1

    // Reset mid-burst abandons it with no done
    issue_burst(0, 2, 3, 8, 0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_word", word, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    issue_burst(0, 2, 3, 8, 0);  wait_idle();

    // Random bursts
    repeat (150) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      issue_burst($urandom_range(0, 20), $urandom_range(0, 6), $urandom_range(0, 4),
                  $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      wait_idle();
    end

`ifdef TRIG_PULSE_WORDGEN_PRBS_EN
    prbs_test();
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
